// File: rtl/rr_request_queue.sv
// Request front-end for the 4-way round-robin arbiter: four per-port FIFOs feed the
// request vector, and the one-hot grant pops a single entry onto a registered output.
module rr_request_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            in_valid,
    input  logic [4*DATA_W-1:0]   in_data,
    output logic [3:0]            in_ready,
    output logic [3:0]            request,
    input  logic [3:0]            grant,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [1:0]            out_src,
    output logic                  grant_err
);

    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

    logic [3:0]        push;
    logic [3:0]        pop;
    logic              grant_onehot;
    logic              grant_multi;
    logic [1:0]        sel;
    logic [DATA_W-1:0] head [4];

    assign grant_onehot = (grant != 4'b0000) && ((grant & (grant - 4'd1)) == 4'b0000);
    assign grant_multi  = (grant != 4'b0000) && !grant_onehot;

    for (genvar i = 0; i < 4; i++) begin : g_queue
        logic [DATA_W-1:0] mem [DEPTH];
        logic [AW-1:0]     wr_ptr;
        logic [AW-1:0]     rd_ptr;
        logic [AW:0]       count;

        // Flags come only from the registered count, so a stale grant to a queue that
        // just drained simply finds it empty and no pop happens.
        assign in_ready[i] = (count != FULL);
        assign request[i]  = (count != '0);
        assign push[i]     = in_valid[i] & in_ready[i];
        assign pop[i]      = grant_onehot & grant[i] & request[i];
        assign head[i]     = mem[rd_ptr];

        always_ff @(posedge clk) begin
            if (push[i])
                mem[wr_ptr] <= in_data[i*DATA_W +: DATA_W];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[i])
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop[i])
                    rd_ptr <= rd_ptr + 1'b1;
                case ({push[i], pop[i]})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_comb begin
        sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (grant[i])
                sel = 2'(i);
        end
    end

    // out_data/out_src keep their last popped values whenever nothing is popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
            grant_err <= 1'b0;
        end else begin
            out_valid <= |pop;
            grant_err <= grant_multi;
            if (|pop) begin
                out_data <= head[sel];
                out_src  <= sel;
            end
        end
    end

endmodule

// File: tb/tb_rr_request_queue.sv
// Directed bench for rr_request_queue: grant is driven by hand in place of the arbiter,
// and every step checks the registered outputs and the queue flags one edge later.
module tb_rr_request_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic [3:0]  request;
    logic [3:0]  grant;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        grant_err;

    int errors = 0;
    int checks = 0;

    rr_request_queue #(.DATA_W(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .request   (request),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .grant_err (grant_err)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d, input logic [3:0] g);
        in_valid = v;
        in_data  = d;
        grant    = g;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic v, input logic [7:0] d,
                               input logic [1:0] s, input logic e);
        checks++;
        assert (out_valid === v) else begin
            errors++;
            $error("[TB] FAIL %s out_valid: observed=%0b expected=%0b", tag, out_valid, v);
        end
        checks++;
        assert (out_data === d) else begin
            errors++;
            $error("[TB] FAIL %s out_data: observed=%0h expected=%0h", tag, out_data, d);
        end
        checks++;
        assert (out_src === s) else begin
            errors++;
            $error("[TB] FAIL %s out_src: observed=%0d expected=%0d", tag, out_src, s);
        end
        checks++;
        assert (grant_err === e) else begin
            errors++;
            $error("[TB] FAIL %s grant_err: observed=%0b expected=%0b", tag, grant_err, e);
        end
    endtask

    task automatic checkFlags(input string tag, input logic [3:0] req, input logic [3:0] rdy);
        checks++;
        assert (request === req) else begin
            errors++;
            $error("[TB] FAIL %s request: observed=%b expected=%b", tag, request, req);
        end
        checks++;
        assert (in_ready === rdy) else begin
            errors++;
            $error("[TB] FAIL %s in_ready: observed=%b expected=%b", tag, in_ready, rdy);
        end
    endtask

    initial begin
        logic [1:0] q;
        logic [3:0] g;
        logic [7:0] d;
        logic [7:0] e;

        // Reset with every requester pushing
        rst      = 1'b1;
        in_valid = 4'b1111;
        in_data  = 32'h3020_1000;
        grant    = 4'b0000;
        #1;
        checkFlags("reset_async", 4'b0000, 4'b1111);
        checkOutput("reset_async", 1'b0, 8'h00, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        checkFlags("reset_held", 4'b0000, 4'b1111);
        checkOutput("reset_held", 1'b0, 8'h00, 2'd0, 1'b0);
        rst = 1'b0;

        applyStimulus(4'b1111, 32'h3020_1000, 4'b0000);
        checkFlags("first_push", 4'b1111, 4'b1111);
        checkOutput("first_push", 1'b0, 8'h00, 2'd0, 1'b0);
        applyStimulus(4'b1111, 32'h3121_1101, 4'b0000);
        checkFlags("second_push", 4'b1111, 4'b1111);

        // Round-robin grants drain two entries from each queue
        for (int k = 0; k < 8; k++) begin
            q = 2'(k % 4);
            g = 4'(1 << q);
            e = 8'((k % 4) * 16 + k / 4);
            applyStimulus(4'b0000, 32'h0, g);
            checkOutput($sformatf("rr_pop%0d", k), 1'b1, e, q, 1'b0);
        end
        checkFlags("rr_drained", 4'b0000, 4'b1111);
        applyStimulus(4'b0000, 32'h0, 4'b0000);
        checkOutput("rr_idle", 1'b0, 8'h31, 2'd3, 1'b0);

        // Single port: three entries in queue 2, continuous grant
        applyStimulus(4'b0100, 32'h00A1_0000, 4'b0000);
        applyStimulus(4'b0100, 32'h00A2_0000, 4'b0000);
        applyStimulus(4'b0100, 32'h00A3_0000, 4'b0000);
        checkFlags("sp_loaded", 4'b0100, 4'b1111);
        applyStimulus(4'b0000, 32'h0, 4'b0100);
        checkOutput("sp_pop1", 1'b1, 8'hA1, 2'd2, 1'b0);
        applyStimulus(4'b0000, 32'h0, 4'b0100);
        checkOutput("sp_pop2", 1'b1, 8'hA2, 2'd2, 1'b0);
        applyStimulus(4'b0000, 32'h0, 4'b0100);
        checkOutput("sp_pop3", 1'b1, 8'hA3, 2'd2, 1'b0);
        checkFlags("sp_drained", 4'b0000, 4'b1111);
        applyStimulus(4'b0000, 32'h0, 4'b0100);
        checkOutput("sp_stale", 1'b0, 8'hA3, 2'd2, 1'b0);

        // Full boundary on queue 0: fifth push is dropped
        applyStimulus(4'b0001, 32'h0000_0011, 4'b0000);
        applyStimulus(4'b0001, 32'h0000_0022, 4'b0000);
        applyStimulus(4'b0001, 32'h0000_0033, 4'b0000);
        checkFlags("full_3", 4'b0001, 4'b1111);
        applyStimulus(4'b0001, 32'h0000_0044, 4'b0000);
        checkFlags("full_4", 4'b0001, 4'b1110);
        applyStimulus(4'b0001, 32'h0000_0055, 4'b0000);
        checkFlags("full_drop", 4'b0001, 4'b1110);
        checkOutput("full_drop", 1'b0, 8'hA3, 2'd2, 1'b0);
        applyStimulus(4'b0000, 32'h0, 4'b0001);
        checkOutput("full_pop1", 1'b1, 8'h11, 2'd0, 1'b0);
        checkFlags("full_pop1", 4'b0001, 4'b1111);
        applyStimulus(4'b0000, 32'h0, 4'b0001);
        checkOutput("full_pop2", 1'b1, 8'h22, 2'd0, 1'b0);
        applyStimulus(4'b0000, 32'h0, 4'b0001);
        checkOutput("full_pop3", 1'b1, 8'h33, 2'd0, 1'b0);
        applyStimulus(4'b0000, 32'h0, 4'b0001);
        checkOutput("full_pop4", 1'b1, 8'h44, 2'd0, 1'b0);
        checkFlags("full_empty", 4'b0000, 4'b1111);
        applyStimulus(4'b0000, 32'h0, 4'b0001);
        checkOutput("full_no5th", 1'b0, 8'h44, 2'd0, 1'b0);

        // Multi-hot grant: error pulse, nothing popped
        applyStimulus(4'b0011, 32'h0000_6B5A, 4'b0000);
        checkFlags("multi_load", 4'b0011, 4'b1111);
        applyStimulus(4'b0000, 32'h0, 4'b0011);
        checkOutput("multi_err", 1'b0, 8'h44, 2'd0, 1'b1);
        checkFlags("multi_err", 4'b0011, 4'b1111);
        applyStimulus(4'b0000, 32'h0, 4'b0000);
        checkOutput("multi_clear", 1'b0, 8'h44, 2'd0, 1'b0);
        applyStimulus(4'b0000, 32'h0, 4'b0001);
        checkOutput("multi_pop0", 1'b1, 8'h5A, 2'd0, 1'b0);
        applyStimulus(4'b0000, 32'h0, 4'b0010);
        checkOutput("multi_pop1", 1'b1, 8'h6B, 2'd1, 1'b0);
        checkFlags("multi_drained", 4'b0000, 4'b1111);

        // Push into an empty queue with a same-cycle grant: pop waits one edge
        applyStimulus(4'b0010, 32'h0000_7700, 4'b0010);
        checkOutput("empty_grant", 1'b0, 8'h6B, 2'd1, 1'b0);
        checkFlags("empty_grant", 4'b0010, 4'b1111);
        applyStimulus(4'b0000, 32'h0, 4'b0010);
        checkOutput("empty_grant_pop", 1'b1, 8'h77, 2'd1, 1'b0);

        // Simultaneous push and pop on queue 3 holding two entries
        applyStimulus(4'b1000, 32'h2E00_0000, 4'b0000);
        applyStimulus(4'b1000, 32'h2F00_0000, 4'b0000);
        checkFlags("pp_preload", 4'b1000, 4'b1111);
        for (int k = 0; k < 6; k++) begin
            d = 8'(8'h30 + k);
            e = (k < 2) ? 8'(8'h2E + k) : 8'(8'h30 + k - 2);
            applyStimulus(4'b1000, {d, 24'h0}, 4'b1000);
            checkOutput($sformatf("pp_step%0d", k), 1'b1, e, 2'd3, 1'b0);
            checkFlags($sformatf("pp_step%0d", k), 4'b1000, 4'b1111);
        end
        applyStimulus(4'b0000, 32'h0, 4'b1000);
        checkOutput("pp_tail0", 1'b1, 8'h34, 2'd3, 1'b0);
        applyStimulus(4'b0000, 32'h0, 4'b1000);
        checkOutput("pp_tail1", 1'b1, 8'h35, 2'd3, 1'b0);
        checkFlags("pp_drained", 4'b0000, 4'b1111);
        applyStimulus(4'b0000, 32'h0, 4'b1000);
        checkOutput("pp_idle", 1'b0, 8'h35, 2'd3, 1'b0);

        // Asynchronous reset mid-operation discards queued and in-flight data
        applyStimulus(4'b0101, 32'h0088_0099, 4'b0000);
        applyStimulus(4'b0000, 32'h0, 4'b0001);
        checkOutput("pre_reset", 1'b1, 8'h99, 2'd0, 1'b0);
        checkFlags("pre_reset", 4'b0100, 4'b1111);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_reset", 1'b0, 8'h00, 2'd0, 1'b0);
        checkFlags("mid_reset", 4'b0000, 4'b1111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
